// File: rtl/kt8_pkg.sv
// Shared definitions for the KT8 memory-mapped I/O block: address decode bit,
// register offsets within the I/O window, STATUS bit positions and the UART
// FSM state encoding used by both the TX and RX paths.
package kt8_pkg;

  // Address bit that selects the I/O window (0x10-0x1F) over data RAM.
  localparam int unsigned IO_BASE_BIT = 4;

  // Register offsets within the I/O window.
  localparam logic [3:0] OffTxData  = 4'h0;
  localparam logic [3:0] OffStatus  = 4'h1;
  localparam logic [3:0] OffRxData  = 4'h2;
  localparam logic [3:0] OffGpioOut = 4'h3;
  localparam logic [3:0] OffGpioIn  = 4'h4;

  // STATUS register bit positions.
  localparam int unsigned StatTxFull   = 0;
  localparam int unsigned StatTxEmpty  = 1;
  localparam int unsigned StatRxValid  = 2;
  localparam int unsigned StatRxOvr    = 3;
  localparam int unsigned StatTxBusy   = 4;
  localparam int unsigned StatRxFrmErr = 5;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_st_e;

endpackage

// File: rtl/kt8_uart_rx.sv
// 8N1 UART receiver.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   rxd_i           - asynchronous serial input (idle high)
//   data_o          - received byte, valid while done_o is high
//   done_o          - one-cycle pulse after the stop-bit sample
//   frame_err_o     - qualifies done_o: stop bit read as 0, byte is bad
module kt8_uart_rx
  import kt8_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rxd_i,
  output logic [7:0] data_o,
  output logic       done_o,
  output logic       frame_err_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]      sync_q;
  logic            prev_q;
  uart_st_e        state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            rx_s;

  assign rx_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (prev_q && !rx_s) state_d = StStart;
      end
      StStart: begin
        // Half-bit check rejects glitches shorter than half a bit.
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StIdle;
          done_d  = 1'b1;
          ferr_d  = !rx_s;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd_i};
      prev_q  <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_o      = shift_q;
  assign done_o      = done_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/kt8_io.sv
// KT8 memory-mapped I/O block for data addresses 0x10-0x1F: RAM write gating,
// read-data mux, 8N1 UART (TX FIFO + shifter, single RX holding register) and
// an 8-bit GPIO port.
// Ports:
//   clk_i, rst_ni        - clock, asynchronous active-low reset
//   address_i/data_i/we_i - CPU data port
//   data_o               - combinational read data to the CPU
//   ram_data_i/ram_we_o  - data RAM read data / gated write enable
//   txd_o/rxd_i          - UART lines
//   gpio_o/gpio_i        - GPIO output register / asynchronous inputs
module kt8_io
  import kt8_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned TX_DEPTH     = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] address_i,
  input  logic [7:0] data_i,
  input  logic       we_i,
  output logic [7:0] data_o,
  input  logic [7:0] ram_data_i,
  output logic       ram_we_o,
  output logic       txd_o,
  input  logic       rxd_i,
  output logic [7:0] gpio_o,
  input  logic [7:0] gpio_i
);

  localparam int unsigned PtrW = $clog2(TX_DEPTH);
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic       io_sel, wr_io;
  logic [3:0] off;

  assign io_sel   = address_i[IO_BASE_BIT];
  assign off      = address_i[3:0];
  assign wr_io    = we_i & io_sel;
  assign ram_we_o = we_i & ~io_sel;

  // TX FIFO
  logic [7:0]    fifo_q [TX_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   fcnt_q, fcnt_d;
  logic            fifo_full, fifo_empty, push, pop;

  assign fifo_full  = (fcnt_q == (PtrW + 1)'(TX_DEPTH));
  assign fifo_empty = (fcnt_q == '0);
  assign push       = wr_io && (off == OffTxData) && !fifo_full;

  always_comb begin
    fcnt_d = fcnt_q;
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + (PtrW + 1)'(1);
      2'b01:   fcnt_d = fcnt_q - (PtrW + 1)'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      fcnt_q <= fcnt_d;
    end
  end

  // TX shifter; txd_q is the line itself so reset drives it high at once.
  uart_st_e        tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            txd_q, txd_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CntW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    pop        = 1'b0;
    case (tx_state_q)
      StIdle: begin
        tx_cnt_d = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_shift_d = fifo_q[rd_ptr_q];
          tx_state_d = StStart;
          txd_d      = 1'b0;
        end
      end
      StStart: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = StData;
          txd_d      = tx_shift_q[0];
        end
      end
      StData: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = StStop;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            txd_d    = tx_shift_q[1];
          end
        end
      end
      StStop: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop        = 1'b1;
            tx_shift_d = fifo_q[rd_ptr_q];
            tx_state_d = StStart;
            txd_d      = 1'b0;
          end else begin
            tx_state_d = StIdle;
            txd_d      = 1'b1;
          end
        end
      end
      default: tx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  assign txd_o = txd_q;

  // RX path and holding register
  logic [7:0] rx_byte;
  logic       rx_done, rx_ferr;

  kt8_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rxd_i      (rxd_i),
    .data_o     (rx_byte),
    .done_o     (rx_done),
    .frame_err_o(rx_ferr)
  );

  logic [7:0] rxdata_q, rxdata_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_ovr_q, rx_ovr_d;
  logic       rx_ferr_q, rx_ferr_d;
  logic       rx_clr;

  assign rx_clr = wr_io && (off == OffRxData);

  always_comb begin
    rxdata_d   = rxdata_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q;
    rx_ferr_d  = rx_ferr_q;
    if (rx_clr) begin
      rx_valid_d = 1'b0;
      rx_ovr_d   = 1'b0;
      rx_ferr_d  = 1'b0;
    end
    // A completing byte overrides a same-edge clear.
    if (rx_done) begin
      if (rx_ferr) begin
        rx_ferr_d = 1'b1;
      end else if (rx_valid_q && !rx_clr) begin
        rx_ovr_d = 1'b1;
      end else begin
        rxdata_d   = rx_byte;
        rx_valid_d = 1'b1;
      end
    end
  end

  // GPIO
  logic [7:0] gpio_out_q, gpio_s1_q, gpio_s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rxdata_q   <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      gpio_out_q <= '0;
      gpio_s1_q  <= '0;
      gpio_s2_q  <= '0;
    end else begin
      rxdata_q   <= rxdata_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
      if (wr_io && (off == OffGpioOut)) gpio_out_q <= data_i;
      gpio_s1_q  <= gpio_i;
      gpio_s2_q  <= gpio_s1_q;
    end
  end

  assign gpio_o = gpio_out_q;

  // Read mux
  logic [7:0] status, rd_io;

  always_comb begin
    status               = '0;
    status[StatTxFull]   = fifo_full;
    status[StatTxEmpty]  = fifo_empty;
    status[StatRxValid]  = rx_valid_q;
    status[StatRxOvr]    = rx_ovr_q;
    status[StatTxBusy]   = (tx_state_q != StIdle);
    status[StatRxFrmErr] = rx_ferr_q;
  end

  always_comb begin
    rd_io = '0;
    case (off)
      OffStatus:  rd_io = status;
      OffRxData:  rd_io = rxdata_q;
      OffGpioOut: rd_io = gpio_out_q;
      OffGpioIn:  rd_io = gpio_s2_q;
      default:    rd_io = '0;
    endcase
  end

  assign data_o = io_sel ? rd_io : ram_data_i;

endmodule

// File: tb/tb_kt8_io.sv
module tb_kt8_io;

  localparam int unsigned Cpb = 4;

  logic       clk;
  logic       rst_n;
  logic [4:0] address;
  logic [7:0] wdata;
  logic       we;
  logic [7:0] rdata;
  logic [7:0] ram_data;
  logic       ram_we;
  logic       txd;
  logic       rxd;
  logic [7:0] gpio_out;
  logic [7:0] gpio_in;

  kt8_io #(
    .CLKS_PER_BIT(Cpb),
    .TX_DEPTH    (4)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .address_i (address),
    .data_i    (wdata),
    .we_i      (we),
    .data_o    (rdata),
    .ram_data_i(ram_data),
    .ram_we_o  (ram_we),
    .txd_o     (txd),
    .rxd_i     (rxd),
    .gpio_o    (gpio_out),
    .gpio_i    (gpio_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef enum int {SelData, SelRamWe, SelGpio, SelTxd} sel_e;
  typedef struct {
    string      name;
    sel_e       sel;
    logic [7:0] val;
  } chk_t;
  typedef struct {
    logic [7:0] b;
    int         exp_start;
    bit         b2b;
  } tx_t;

  chk_t chk_q[$];
  tx_t  tx_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   tx_ignore = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected 40 per-cycle line samples of one frame.
  function automatic logic [39:0] frame_bits(input logic [7:0] b);
    logic [9:0]  f;
    logic [39:0] r;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < 40; k++) r[k] = f[k/4];
    return r;
  endfunction

  function automatic void expect_v(input string name, input sel_e sel, input logic [7:0] v);
    chk_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = v;
    chk_q.push_back(e);
  endfunction

  // Register/pin monitor: checks everything queued for this cycle.
  chk_t       mon_e;
  logic [7:0] mon_act;
  initial begin
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0) begin
        mon_e = chk_q.pop_front();
        case (mon_e.sel)
          SelData:  mon_act = rdata;
          SelRamWe: mon_act = {7'd0, ram_we};
          SelGpio:  mon_act = gpio_out;
          default:  mon_act = {7'd0, txd};
        endcase
        n_chk++;
        if (mon_act !== mon_e.val) begin
          n_fail++;
          $display("FAIL %s: got %02h expected %02h", mon_e.name, mon_act, mon_e.val);
        end
      end
    end
  end

  // TX line monitor: decodes frames and compares against the TX queue.
  bit          tx_busy = 1'b0;
  bit          tx_have = 1'b0;
  int          tx_idx = 0;
  int          tx_start = 0;
  int          tx_prev = -1000;
  logic [39:0] tx_samp;
  tx_t         tx_cur;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_busy = 1'b0;
      end else if (!tx_busy) begin
        if (txd === 1'b0) begin
          tx_busy  = 1'b1;
          tx_idx   = 1;
          tx_samp  = '1;
          tx_samp[0] = 1'b0;
          tx_start = cyc;
          if (tx_q.size() > 0) begin
            tx_cur  = tx_q.pop_front();
            tx_have = 1'b1;
            if (tx_cur.exp_start >= 0) begin
              n_chk++;
              if (cyc != tx_cur.exp_start) begin
                n_fail++;
                $display("FAIL tx_start_latency: got cycle %0d expected %0d", cyc,
                         tx_cur.exp_start);
              end
            end
            if (tx_cur.b2b) begin
              n_chk++;
              if (cyc != tx_prev + 40) begin
                n_fail++;
                $display("FAIL tx_gap: start at %0d expected %0d", cyc, tx_prev + 40);
              end
            end
          end else begin
            tx_have = 1'b0;
            if (!tx_ignore) begin
              n_chk++;
              n_fail++;
              $display("FAIL tx_unexpected_frame: got start at %0d expected none", cyc);
            end
          end
        end
      end else begin
        tx_samp[tx_idx] = txd;
        tx_idx++;
        if (tx_idx == 40) begin
          tx_busy = 1'b0;
          tx_prev = tx_start;
          if (tx_have) begin
            n_chk++;
            if (tx_samp !== frame_bits(tx_cur.b)) begin
              n_fail++;
              $display("FAIL tx_frame_%02h: got %010h expected %010h", tx_cur.b, tx_samp,
                       frame_bits(tx_cur.b));
            end
          end
        end
      end
    end
  end

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) settle();
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] v, input string name);
    address = a;
    we      = 1'b0;
    expect_v(name, SelData, v);
    settle();
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    address = a;
    wdata   = d;
    we      = 1'b1;
    expect_v("ram_we", SelRamWe, {7'd0, ~a[4]});
    settle();
    we = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b, input int exp_start, input bit b2b);
    tx_t t;
    t.b         = b;
    t.exp_start = exp_start;
    t.b2b       = b2b;
    tx_q.push_back(t);
  endtask

  task automatic wait_tx(input int budget);
    int n;
    n = 0;
    while ((tx_q.size() > 0 || tx_busy) && n < budget) begin
      settle();
      n++;
    end
    if (n == budget) begin
      n_chk++;
      n_fail++;
      $display("FAIL tx_timeout: got %0d frames pending expected 0", tx_q.size());
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    idle(Cpb);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(Cpb);
    end
    rxd = stop;
    idle(Cpb);
    rxd = 1'b1;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got no end of test expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    rst_n    = 1'b0;
    address  = '0;
    wdata    = '0;
    we       = 1'b0;
    ram_data = 8'h5A;
    rxd      = 1'b1;
    gpio_in  = 8'h00;
    #1;
    idle(2);
    // Values while reset is held
    expect_v("txd_in_reset", SelTxd, 8'h01);
    expect_v("gpio_in_reset", SelGpio, 8'h00);
    rd(5'h11, 8'h02, "status_in_reset");
    rst_n = 1'b1;
    idle(1);
    rd(5'h11, 8'h02, "status_reset");
    rd(5'h12, 8'h00, "rxdata_reset");
    rd(5'h10, 8'h00, "txdata_read");
    expect_v("txd_idle", SelTxd, 8'h01);

    // RAM gating and GPIO_OUT
    wr(5'h03, 8'h05);
    wr(5'h13, 8'h05);
    rd(5'h13, 8'h05, "gpio_out_rd");
    rd(5'h03, 8'h5A, "ram_rd");
    expect_v("gpio_o", SelGpio, 8'h05);
    rd(5'h15, 8'h00, "unmapped_15");
    wr(5'h1F, 8'hEE);
    rd(5'h1F, 8'h00, "unmapped_1f");

    // GPIO_IN synchronizer: visible two edges after the change
    gpio_in = 8'hC3;
    rd(5'h14, 8'h00, "gpio_in_0edge");
    rd(5'h14, 8'h00, "gpio_in_1edge");
    rd(5'h14, 8'hC3, "gpio_in_2edge");

    // Single TX frame
    push_tx(8'hA5, cyc + 2, 1'b0);
    wr(5'h10, 8'hA5);
    idle(2);
    rd(5'h11, 8'h12, "status_tx_busy");
    idle(45);
    rd(5'h11, 8'h02, "status_tx_done");
    wait_tx(100);

    // Burst of five: first entry pops at the edge after its write
    for (int i = 1; i <= 5; i++) begin
      push_tx(8'(i), (i == 1) ? cyc + 2 : -1, i > 1);
    end
    for (int i = 1; i <= 5; i++) wr(5'h10, 8'(i));
    rd(5'h11, 8'h11, "status_tx_full");
    wait_tx(400);
    rd(5'h11, 8'h02, "status_burst_done");

    // RX: good byte, then overrun, then clear
    send_rx(8'h3C, 1'b1);
    idle(6);
    rd(5'h11, 8'h06, "status_rx_valid");
    rd(5'h12, 8'h3C, "rxdata_3c");
    send_rx(8'h7E, 1'b1);
    idle(6);
    rd(5'h11, 8'h0E, "status_rx_overrun");
    rd(5'h12, 8'h3C, "rxdata_kept");
    wr(5'h12, 8'h00);
    rd(5'h11, 8'h02, "status_rx_cleared");

    // RX frame error
    send_rx(8'h55, 1'b0);
    idle(6);
    rd(5'h11, 8'h22, "status_frame_err");
    rd(5'h12, 8'h3C, "rxdata_after_ferr");
    wr(5'h12, 8'h00);
    rd(5'h11, 8'h02, "status_ferr_cleared");

    // One-cycle glitch on rxd
    rxd = 1'b0;
    idle(1);
    rxd = 1'b1;
    idle(8);
    rd(5'h11, 8'h02, "status_glitch");

    // Reset in the middle of a TX frame
    wr(5'h13, 8'hFF);
    expect_v("gpio_o_ff", SelGpio, 8'hFF);
    tx_ignore = 1'b1;
    wr(5'h10, 8'h81);
    idle(15);
    expect_v("txd_mid_frame", SelTxd, 8'h00);
    settle();
    rst_n = 1'b0;
    expect_v("txd_async_reset", SelTxd, 8'h01);
    expect_v("gpio_o_reset", SelGpio, 8'h00);
    rd(5'h11, 8'h02, "status_mid_reset");
    rst_n = 1'b1;
    idle(2);
    rd(5'h11, 8'h02, "status_after_reset");
    expect_v("txd_after_reset", SelTxd, 8'h01);
    idle(50);
    tx_ignore = 1'b0;
    rd(5'h13, 8'h00, "gpio_out_after_reset");
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
